booth_issue: RTL and testbench

Operand issue stage directly upstream of the Booth control unit in the 3-bit Booth multiplier. Accepts a multiplicand/multiplier pair over a valid/ready handshake and latches it. Radix-4 recodes the multiplier into the two digit codes the control unit consumes (`cmp0`, `cmp1`), and sequences the control unit through one multiply by driving its reset. Holds operands and codes stable until the control unit reports completion, then pulses `op_done`.

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_recode.sv | 21 ++
 rtl/booth_issue.sv | 114 +++++++++++
 tb/tb_booth_issue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth issue stage: radix-4 digit codes and FSM state encoding.
package booth_pkg;

  localparam logic [2:0] CMP_ZERO = 3'b000;
  localparam logic [2:0] CMP_P1   = 3'b001;
  localparam logic [2:0] CMP_P2   = 3'b010;
  localparam logic [2:0] CMP_M2   = 3'b011;
  localparam logic [2:0] CMP_M1   = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: one 3-bit multiplier window to one digit code. Purely combinational.
module booth_recode
  import booth_pkg::*;
(
  input  logic [2:0] win,
  output logic [2:0] code
);

  always_comb begin
    code = CMP_ZERO;
    case (win)
      3'b000, 3'b111: code = CMP_ZERO;
      3'b001, 3'b010: code = CMP_P1;
      3'b011:         code = CMP_P2;
      3'b100:         code = CMP_M2;
      3'b101, 3'b110: code = CMP_M1;
      default:        code = CMP_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_issue.sv
// Operand issue stage for the Booth control unit: latches operands, recodes, sequences cu_rst.
// Optional RUN watchdog enabled by defining BOOTH_ISSUE_TIMEOUT_EN.
module booth_issue
  import booth_pkg::*;
#(
  parameter int TIMEOUT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_mcand,
  input  logic [2:0] in_mplier,
  output logic [2:0] mcand_o,
  output logic [2:0] cmp0,
  output logic [2:0] cmp1,
  output logic       cu_rst,
  input  logic       cu_done,
  output logic       op_done,
  output logic       err
);

  state_t     state, state_nxt;
  logic       accept;
  logic       done_nxt;
  logic       err_nxt;
  logic       to_hit;
  logic [2:0] code0, code1;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid & in_ready;

  // Multiplier is sign-extended to 4 bits, so digit 1 sees b2 twice.
  booth_recode u_recode0 (
    .win  ({in_mplier[1:0], 1'b0}),
    .code (code0)
  );

  booth_recode u_recode1 (
    .win  ({in_mplier[2], in_mplier[2], in_mplier[1]}),
    .code (code1)
  );

`ifdef BOOTH_ISSUE_TIMEOUT_EN
  localparam logic [2:0] TO_LIM = 3'(TIMEOUT);
  logic [2:0] cnt;

  // Fires on the edge at which the RUN-cycle count would reach the limit.
  assign to_hit = ((cnt + 3'd1) == TO_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 3'd0;
    end else if (accept) begin
      cnt <= 3'd0;
    end else if (state == ST_RUN) begin
      cnt <= cnt + 3'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_hit         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A completion on the same edge as the timeout takes priority.
        if (cu_done) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (to_hit) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cu_rst  <= 1'b0;
      op_done <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cu_rst  <= (state_nxt == ST_RUN);
      op_done <= done_nxt;
      err     <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_o <= 3'b000;
      cmp0    <= CMP_ZERO;
      cmp1    <= CMP_ZERO;
    end else if (accept) begin
      mcand_o <= in_mcand;
      cmp0    <= code0;
      cmp1    <= code1;
    end
  end

endmodule

// File: tb/tb_booth_issue.sv
// Directed bench for booth_issue with a small behavioural model of the Booth control unit.
module tb_booth_issue;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_mcand;
  logic [2:0] in_mplier;
  logic [2:0] mcand_o;
  logic [2:0] cmp0;
  logic [2:0] cmp1;
  logic       cu_rst;
  logic       cu_done;
  logic       op_done;
  logic       err;

  int tests = 0;
  int fails = 0;

  // Control unit model: first state E0-E1, second E1-E2, done from E2.
  logic [1:0] cu_st;
  logic       cu_en;
  logic       cu_force;

  always_ff @(posedge clk or negedge cu_rst) begin
    if (!cu_rst) cu_st <= 2'd0;
    else if (cu_st != 2'd2) cu_st <= cu_st + 2'd1;
  end

  assign cu_done = ((cu_st == 2'd2) & cu_en) | cu_force;

  booth_issue #(.TIMEOUT(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mcand  (in_mcand),
    .in_mplier (in_mplier),
    .mcand_o   (mcand_o),
    .cmp0      (cmp0),
    .cmp1      (cmp1),
    .cu_rst    (cu_rst),
    .cu_done   (cu_done),
    .op_done   (op_done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] mcand;
    logic [2:0] mplier;
    logic [2:0] c0;
    logic [2:0] c1;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // mplier -> {digit0, digit1}: value = 4*d1 + d0
    vt[0] = '{3'b001, 3'b000, 3'b000, 3'b000};
    vt[1] = '{3'b010, 3'b001, 3'b001, 3'b000};
    vt[2] = '{3'b011, 3'b010, 3'b011, 3'b001};
    vt[3] = '{3'b100, 3'b011, 3'b100, 3'b001};
    vt[4] = '{3'b101, 3'b100, 3'b000, 3'b100};
    vt[5] = '{3'b110, 3'b101, 3'b001, 3'b100};
    vt[6] = '{3'b111, 3'b110, 3'b011, 3'b000};
    vt[7] = '{3'b011, 3'b111, 3'b100, 3'b000};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_mcand  = 3'b000;
    in_mplier = 3'b000;
    cu_en     = 1'b1;
    cu_force  = 1'b0;

    #12;
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_cu_rst",   8'(cu_rst),   8'd0);
    chk("rst_mcand",    8'(mcand_o),  8'd0);
    chk("rst_cmp0",     8'(cmp0),     8'd0);
    chk("rst_cmp1",     8'(cmp1),     8'd0);
    chk("rst_op_done",  8'(op_done),  8'd0);
    chk("rst_err",      8'(err),      8'd0);

    @(negedge clk);
    rst = 1'b1;
    cyc();

    // Table-driven: full recode coverage plus E0..E4 timing per operation
    for (int i = 0; i < 8; i++) begin
      in_mcand  = vt[i].mcand;
      in_mplier = vt[i].mplier;
      in_valid  = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk($sformatf("v%0d_mcand", i), 8'(mcand_o), 8'(vt[i].mcand));
      chk($sformatf("v%0d_cmp0", i),  8'(cmp0),    8'(vt[i].c0));
      chk($sformatf("v%0d_cmp1", i),  8'(cmp1),    8'(vt[i].c1));
      chk($sformatf("v%0d_cu_rst", i), 8'(cu_rst), 8'd1);
      chk($sformatf("v%0d_busy", i),  8'(in_ready), 8'd0);
      cyc();
      chk($sformatf("v%0d_e1_done", i), 8'(op_done), 8'd0);
      cyc();
      chk($sformatf("v%0d_e2_done", i), 8'(op_done), 8'd0);
      cyc();
      chk($sformatf("v%0d_e3_done", i), 8'(op_done), 8'd1);
      chk($sformatf("v%0d_e3_rdy", i),  8'(in_ready), 8'd1);
      chk($sformatf("v%0d_e3_curst", i), 8'(cu_rst), 8'd0);
      cyc();
      chk($sformatf("v%0d_e4_done", i), 8'(op_done), 8'd0);
    end

    // Back-to-back with operands and in_valid changing during RUN
    in_mcand  = 3'b010;
    in_mplier = 3'b011;
    in_valid  = 1'b1;
    cyc();
    chk("b2b_a_mcand", 8'(mcand_o), 8'h2);
    in_mcand  = 3'b101;
    in_mplier = 3'b100;
    cyc();
    chk("b2b_e1_rdy",  8'(in_ready), 8'd0);
    chk("b2b_e1_cmp0", 8'(cmp0), 8'h4);
    in_valid = 1'b0;
    cyc();
    chk("b2b_e2_rdy",   8'(in_ready), 8'd0);
    chk("b2b_e2_mcand", 8'(mcand_o), 8'h2);
    chk("b2b_e2_cmp1",  8'(cmp1), 8'h1);
    in_valid = 1'b1;
    cyc();
    chk("b2b_e3_done",  8'(op_done), 8'd1);
    chk("b2b_e3_rdy",   8'(in_ready), 8'd1);
    chk("b2b_e3_mcand", 8'(mcand_o), 8'h2);
    cyc();
    in_valid = 1'b0;
    chk("b2b_e4_mcand", 8'(mcand_o), 8'h5);
    chk("b2b_e4_cmp0",  8'(cmp0), 8'h0);
    chk("b2b_e4_cmp1",  8'(cmp1), 8'h4);
    chk("b2b_e4_rdy",   8'(in_ready), 8'd0);
    chk("b2b_e4_done",  8'(op_done), 8'd0);
    cyc();
    cyc();
    cyc();
    chk("b2b_e7_done", 8'(op_done), 8'd1);
    cyc();

    // Reset asserted mid-operation
    in_mcand  = 3'b111;
    in_mplier = 3'b011;
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_cu_rst", 8'(cu_rst),   8'd0);
    chk("mid_rst_rdy",    8'(in_ready), 8'd1);
    chk("mid_rst_cmp0",   8'(cmp0),     8'd0);
    chk("mid_rst_cmp1",   8'(cmp1),     8'd0);
    chk("mid_rst_mcand",  8'(mcand_o),  8'd0);
    chk("mid_rst_done",   8'(op_done),  8'd0);
    cyc();
    cyc();
    chk("mid_rst_nodone", 8'(op_done), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("post_rst_rdy",  8'(in_ready), 8'd1);
    chk("post_rst_done", 8'(op_done),  8'd0);

    // cu_done while idle must be ignored
    cu_force = 1'b1;
    cyc();
    cyc();
    chk("idle_cudone_done",  8'(op_done), 8'd0);
    chk("idle_cudone_rdy",   8'(in_ready), 8'd1);
    chk("idle_cudone_curst", 8'(cu_rst), 8'd0);
    cu_force = 1'b0;
    cyc();

    // cu_done held low
    cu_en     = 1'b0;
    in_mcand  = 3'b001;
    in_mplier = 3'b001;
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
`ifdef BOOTH_ISSUE_TIMEOUT_EN
      chk($sformatf("to_err_%0d", k), 8'(err), (k == 7) ? 8'd1 : 8'd0);
      chk($sformatf("to_rdy_%0d", k), 8'(in_ready), (k == 7) ? 8'd1 : 8'd0);
`else
      chk($sformatf("to_err_%0d", k), 8'(err), 8'd0);
      chk($sformatf("to_rdy_%0d", k), 8'(in_ready), 8'd0);
`endif
      chk($sformatf("to_done_%0d", k), 8'(op_done), 8'd0);
    end
`ifdef BOOTH_ISSUE_TIMEOUT_EN
    cyc();
    chk("to_err_clear", 8'(err), 8'd0);
    chk("to_curst_low", 8'(cu_rst), 8'd0);
    // cu_done arriving on the timeout edge wins
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) cyc();
    cu_en = 1'b1;
    cyc();
    chk("tie_done", 8'(op_done), 8'd1);
    chk("tie_err",  8'(err), 8'd0);
    cyc();
`else
    cu_en = 1'b1;
    cyc();
    chk("late_done",  8'(op_done), 8'd1);
    chk("late_err",   8'(err), 8'd0);
    cyc();
`endif
    cu_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
